rr_quantum_arbiter: RTL and testbench



---
 rtl/rr_quantum_arbiter_if.sv | 28 ++
 rtl/rr_quantum_arbiter.sv | 132 +++++++++++++
 tb/tb_rr_quantum_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rr_quantum_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// The arbiter connects through the slave modport; requesters use master.
interface rr_quantum_arbiter_if #(
  parameter int N   = 2,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   request;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           preempt;

  modport master (
    output request,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  preempt
  );

  modport slave (
    input  request,
    output grant,
    output grant_valid,
    output grant_id,
    output preempt
  );
endinterface

// File: rtl/rr_quantum_arbiter.sv
// Round-robin arbiter with registered one-hot grants; a holder is preempted
// after QUANTUM cycles if anyone else is waiting.
module rr_quantum_arbiter #(
  parameter int N       = 2,
  parameter int QUANTUM = 4,
  parameter int IDW     = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_quantum_arbiter_if.slave  arb_io
);
  localparam int HCW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(QUANTUM - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] id_q, id_d;
  logic           valid_q, valid_d;
  logic           preempt_q, preempt_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0] hold_q, hold_d;

  logic [N-1:0]   cand;
  logic [N-1:0]   win_oh;
  logic           found;
  logic [IDW-1:0] win;
  logic [IDW:0]   idx;
  logic [IDW:0]   ptr_next;
  logic           holder_req;
  logic           take;

  // The holder is masked out while BUSY so "found" means a competitor exists.
  assign cand       = (state_q == BUSY) ? (arb_io.request & ~grant_q) : arb_io.request;
  assign holder_req = |(arb_io.request & grant_q);

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
      if (cand[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_win_oh
    assign win_oh[gi] = found && (win == IDW'(gi));
  end

  always_comb begin
    ptr_next = {1'b0, win} + 1'b1;
    if (ptr_next == (IDW+1)'(N)) ptr_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = BUSY;
      BUSY:    if (!holder_req && !found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Release outranks expiry, so a holder dropping at quantum end never pulses preempt.
  always_comb begin
    grant_d   = grant_q;
    id_d      = id_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    take      = 1'b0;
    case (state_q)
      IDLE: take = found;
      BUSY: begin
        if (!holder_req) begin
          if (found) begin
            take = 1'b1;
          end else begin
            grant_d = '0;
            id_d    = '0;
            valid_d = 1'b0;
          end
        end else if (hold_q == HOLD_MAX && found) begin
          take      = 1'b1;
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (take) begin
      grant_d = win_oh;
      id_d    = win;
      valid_d = 1'b1;
      hold_d  = '0;
      ptr_d   = ptr_next[IDW-1:0];
    end
  end

  assign arb_io.grant       = grant_q;
  assign arb_io.grant_id    = id_q;
  assign arb_io.grant_valid = valid_q;
  assign arb_io.preempt     = preempt_q;
endmodule

// File: tb/tb_rr_quantum_arbiter.sv
// Scoreboard bench for rr_quantum_arbiter: a 2-requester (QUANTUM=4) and a
// 4-requester (QUANTUM=2) instance driven with directed vectors.
module tb_rr_quantum_arbiter;
  logic clk = 1'b0;
  logic rst2 = 1'b1;
  logic rst4 = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  logic final_chk = 1'b0;
  logic final_done = 1'b0;

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic [1:0] id;
    logic       p;
  } exp_t;

  exp_t q2[$];
  exp_t q4[$];

  rr_quantum_arbiter_if #(.N(2)) if2 ();
  rr_quantum_arbiter_if #(.N(4)) if4 ();

  rr_quantum_arbiter #(.N(2), .QUANTUM(4)) dut2 (.clk(clk), .rst(rst2), .arb_io(if2));
  rr_quantum_arbiter #(.N(4), .QUANTUM(2)) dut4 (.clk(clk), .rst(rst4), .arb_io(if4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (actual timeout, required completion)");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (!rst2) assert (!$isunknown(if2.request)) else $error("X/Z on 2-requester request");
    if (!rst4) assert (!$isunknown(if4.request)) else $error("X/Z on 4-requester request");
  end

  task automatic check(input string nm, input exp_t e, input logic [3:0] g,
                       input logic [1:0] id, input logic v, input logic p);
    checks++;
    if (g === e.g && id === e.id && v === (|e.g) && p === e.p && $onehot0(g))
      passes++;
    else
      $display("FAIL %s cyc%0d: actual grant=%b id=%0d valid=%b preempt=%b, required grant=%b id=%0d valid=%b preempt=%b",
               nm, e.cyc, g, id, v, p, e.g, e.id, |e.g, e.p);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q2.size() > 0 && q2[0].cyc <= cyc) begin
      e = q2.pop_front();
      check("n2", e, {2'b00, if2.grant}, {1'b0, if2.grant_id}, if2.grant_valid, if2.preempt);
      $display("n2 cyc%0d req=%b grant=%b id=%0d preempt=%b", e.cyc, if2.request, if2.grant, if2.grant_id, if2.preempt);
    end
    while (q4.size() > 0 && q4[0].cyc <= cyc) begin
      e = q4.pop_front();
      check("n4", e, if4.grant, if4.grant_id, if4.grant_valid, if4.preempt);
      $display("n4 cyc%0d req=%b grant=%b id=%0d preempt=%b", e.cyc, if4.request, if4.grant, if4.grant_id, if4.preempt);
    end
    if (final_chk && !final_done) begin
      final_done = 1'b1;
      checks++;
      if (q2.size() == 0 && q4.size() == 0) passes++;
      else $display("FAIL drain: actual %0d/%0d entries left, required 0/0", q2.size(), q4.size());
    end
  end

  task automatic step2(input logic r, input logic [1:0] req, input logic [1:0] g,
                       input logic id, input logic p);
    exp_t e;
    @(posedge clk);
    #1;
    rst2 = r;
    if2.request = req;
    e.cyc = cyc + 1; e.g = {2'b00, g}; e.id = {1'b0, id}; e.p = p;
    q2.push_back(e);
  endtask

  task automatic step4(input logic r, input logic [3:0] req, input logic [3:0] g,
                       input logic [1:0] id, input logic p);
    exp_t e;
    @(posedge clk);
    #1;
    rst4 = r;
    if4.request = req;
    e.cyc = cyc + 1; e.g = g; e.id = id; e.p = p;
    q4.push_back(e);
  endtask

  // Test 6 expectations: requester 2 is skipped, each holder lasts 2 cycles.
  logic [3:0] t6_g  [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b1000,
                             4'b1000, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
  logic [1:0] t6_id [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1};
  logic       t6_p  [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    if2.request = '0;
    if4.request = '0;
    // Test 1: idle after reset
    step2(1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step2(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    // Test 2: lone requester 0
    for (int i = 0; i < 10; i++) step2(1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
    step2(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    // Test 3: both requesting, quantum rotation from ptr=0
    step2(1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i < 4)      step2(1'b0, 2'b11, 2'b01, 1'b0, 1'b0);
      else if (i < 8) step2(1'b0, 2'b11, 2'b10, 1'b1, i == 4);
      else            step2(1'b0, 2'b11, 2'b01, 1'b0, i == 8);
    end
    // Test 4: holder releases exactly at quantum end as requester 1 arrives
    step2(1'b0, 2'b10, 2'b10, 1'b1, 1'b0);
    step2(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    step2(1'b0, 2'b11, 2'b01, 1'b0, 1'b0);
    // Test 5: reset mid-grant while requester 1 holds
    for (int i = 0; i < 3; i++) step2(1'b0, 2'b11, 2'b01, 1'b0, 1'b0);
    step2(1'b0, 2'b11, 2'b10, 1'b1, 1'b1);
    step2(1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
    step2(1'b0, 2'b11, 2'b01, 1'b0, 1'b0);
    step2(1'b0, 2'b11, 2'b01, 1'b0, 1'b0);
    step2(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    // Competitor arrives while the lone holder is saturated
    for (int i = 0; i < 6; i++) step2(1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
    step2(1'b0, 2'b11, 2'b10, 1'b1, 1'b1);
    step2(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    // Test 6: N=4, QUANTUM=2
    step4(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++) step4(1'b0, 4'b1011, t6_g[i], t6_id[i], t6_p[i]);
    step4(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);

    repeat (5) @(posedge clk);
    final_chk = 1'b1;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
